// File: rtl/fetch_unit.sv
// Instruction fetch unit: walks the PC through IDLE -> REQ -> VALID, one instruction
// per handshake, with branch redirect and decode stall.
module fetch_unit #(
   parameter int                 WIDTH    = 16,
   parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [WIDTH-1:0]  branch_target,
   output logic              imem_req,
   output logic [WIDTH-1:0]  imem_addr,
   input  logic              imem_ready,
   input  logic [15:0]       imem_rdata,
   output logic [15:0]       instr,
   output logic              instr_valid,
   output logic [WIDTH-1:0]  pc,
   output logic [WIDTH-1:0]  pc_plus1
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      VALID = 2'd2
   } state_t;

   state_t            state_reg, state_next;
   logic [WIDTH-1:0]  pc_reg, pc_next;
   logic [15:0]       instr_reg, instr_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         pc_reg    <= RESET_PC;
         instr_reg <= 16'h0000;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         instr_reg <= instr_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      instr_next = instr_reg;
      case (state_reg)
         IDLE: state_next = REQ;
         REQ: begin
            // A redirect drops whatever the memory returns in the same cycle.
            if (branch_taken) begin
               pc_next = branch_target;
            end else if (imem_ready) begin
               instr_next = imem_rdata;
               state_next = VALID;
            end
         end
         VALID: begin
            if (!stall) begin
               pc_next    = branch_taken ? branch_target : pc_plus1;
               state_next = REQ;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Outputs decode straight from state so the async reset reaches them at once.
   assign imem_req    = (state_reg == REQ);
   assign instr_valid = (state_reg == VALID);
   assign imem_addr   = pc_reg;
   assign pc          = pc_reg;
   assign pc_plus1    = pc_reg + 1'b1;
   assign instr       = instr_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: inputs change and outputs are sampled on the falling edge.
module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        branch_taken;
   logic [15:0] branch_target;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ready;
   logic [15:0] imem_rdata;
   logic [15:0] instr;
   logic        instr_valid;
   logic [15:0] pc;
   logic [15:0] pc_plus1;

   int n_checks = 0;
   int n_fail   = 0;

   fetch_unit #(.WIDTH(16), .RESET_PC(16'h0000)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .imem_rdata    (imem_rdata),
      .instr         (instr),
      .instr_valid   (instr_valid),
      .pc            (pc),
      .pc_plus1      (pc_plus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset;
      #2;
      n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, 16'h0000); end
      n_checks++; if (instr !== 16'h0000) begin n_fail++; $display("FAIL reset_instr: got %h want %h", instr, 16'h0000); end
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
      n_checks++; if (imem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_addr: got %h want %h", imem_addr, 16'h0000); end
      repeat (2) @(negedge clk);
      $display("test_reset: pc=%h instr=%h valid=%b req=%b", pc, instr, instr_valid, imem_req);
   endtask

   task automatic test_reset_release;
      imem_ready = 1'b1; imem_rdata = 16'h1111; rst_n = 1'b1;
      #1;
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_req: got %b want 0", imem_req); end
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b want 0", instr_valid); end
      @(negedge clk);
      n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rel_req: got %b want 1", imem_req); end
      n_checks++; if (imem_addr !== 16'h0000) begin n_fail++; $display("FAIL rel_addr: got %h want %h", imem_addr, 16'h0000); end
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rel_valid_req: got %b want 0", instr_valid); end
      @(negedge clk);
      n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL rel_valid: got %b want 1", instr_valid); end
      n_checks++; if (instr !== 16'h1111) begin n_fail++; $display("FAIL rel_instr: got %h want %h", instr, 16'h1111); end
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rel_req_valid: got %b want 0", imem_req); end
      $display("test_reset_release: pc=%h instr=%h valid=%b", pc, instr, instr_valid);
   endtask

   task automatic test_sequential;
      imem_rdata = 16'h2222;
      @(negedge clk);
      n_checks++; if (pc !== 16'h0001) begin n_fail++; $display("FAIL seq_pc1: got %h want %h", pc, 16'h0001); end
      n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL seq_req1: got %b want 1", imem_req); end
      @(negedge clk);
      n_checks++; if (instr !== 16'h2222) begin n_fail++; $display("FAIL seq_instr1: got %h want %h", instr, 16'h2222); end
      n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid1: got %b want 1", instr_valid); end
      imem_rdata = 16'h3333;
      @(negedge clk);
      n_checks++; if (pc !== 16'h0002) begin n_fail++; $display("FAIL seq_pc2: got %h want %h", pc, 16'h0002); end
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL seq_valid_gap: got %b want 0", instr_valid); end
      @(negedge clk);
      n_checks++; if (instr !== 16'h3333) begin n_fail++; $display("FAIL seq_instr2: got %h want %h", instr, 16'h3333); end
      n_checks++; if (pc_plus1 !== 16'h0003) begin n_fail++; $display("FAIL seq_pc_plus1: got %h want %h", pc_plus1, 16'h0003); end
      $display("test_sequential: pc=%h instr=%h", pc, instr);
   endtask

   task automatic test_wait_states;
      branch_taken = 1'b1; branch_target = 16'h0005; imem_ready = 1'b0;
      @(negedge clk);
      branch_taken = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL wait_req[%0d]: got %b want 1", i, imem_req); end
         n_checks++; if (imem_addr !== 16'h0005) begin n_fail++; $display("FAIL wait_addr[%0d]: got %h want %h", i, imem_addr, 16'h0005); end
         n_checks++; if (instr !== 16'h3333) begin n_fail++; $display("FAIL wait_instr[%0d]: got %h want %h", i, instr, 16'h3333); end
         if (i == 2) begin
            // Stall is raised during the capture cycle; REQ must ignore it.
            imem_ready = 1'b1; imem_rdata = 16'h5555; stall = 1'b1;
         end
         @(negedge clk);
      end
      n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL wait_capture_valid: got %b want 1", instr_valid); end
      n_checks++; if (instr !== 16'h5555) begin n_fail++; $display("FAIL wait_capture_instr: got %h want %h", instr, 16'h5555); end
      n_checks++; if (pc !== 16'h0005) begin n_fail++; $display("FAIL wait_capture_pc: got %h want %h", pc, 16'h0005); end
      $display("test_wait_states: pc=%h instr=%h", pc, instr);
   endtask

   task automatic test_stall_branch;
      stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h0077; imem_rdata = 16'h9999; imem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++; if (pc !== 16'h0005) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h want %h", i, pc, 16'h0005); end
         n_checks++; if (instr !== 16'h5555) begin n_fail++; $display("FAIL stall_instr[%0d]: got %h want %h", i, instr, 16'h5555); end
         n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b want 1", i, instr_valid); end
      end
      stall = 1'b0; branch_target = 16'h00A0;
      @(negedge clk);
      branch_taken = 1'b0; imem_ready = 1'b0;
      n_checks++; if (imem_addr !== 16'h00A0) begin n_fail++; $display("FAIL stall_redirect_addr: got %h want %h", imem_addr, 16'h00A0); end
      n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL stall_redirect_req: got %b want 1", imem_req); end
      n_checks++; if (instr !== 16'h5555) begin n_fail++; $display("FAIL stall_redirect_instr: got %h want %h", instr, 16'h5555); end
      $display("test_stall_branch: pc=%h instr=%h", pc, instr);
   endtask

   task automatic test_branch_collision;
      branch_taken = 1'b1; branch_target = 16'h0010;
      @(negedge clk);
      n_checks++; if (imem_addr !== 16'h0010) begin n_fail++; $display("FAIL coll_setup_addr: got %h want %h", imem_addr, 16'h0010); end
      n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL coll_setup_req: got %b want 1", imem_req); end
      imem_ready = 1'b1; imem_rdata = 16'hBEEF; branch_target = 16'h0040;
      @(negedge clk);
      branch_taken = 1'b0; imem_rdata = 16'h4040;
      n_checks++; if (instr !== 16'h5555) begin n_fail++; $display("FAIL coll_instr: got %h want %h", instr, 16'h5555); end
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL coll_valid: got %b want 0", instr_valid); end
      n_checks++; if (imem_addr !== 16'h0040) begin n_fail++; $display("FAIL coll_addr: got %h want %h", imem_addr, 16'h0040); end
      @(negedge clk);
      n_checks++; if (instr !== 16'h4040) begin n_fail++; $display("FAIL coll_after_instr: got %h want %h", instr, 16'h4040); end
      n_checks++; if (pc !== 16'h0040) begin n_fail++; $display("FAIL coll_after_pc: got %h want %h", pc, 16'h0040); end
      $display("test_branch_collision: pc=%h instr=%h", pc, instr);
   endtask

   task automatic test_wrap;
      branch_taken = 1'b1; branch_target = 16'hFFFF; imem_ready = 1'b0;
      @(negedge clk);
      n_checks++; if (pc !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_pc: got %h want %h", pc, 16'hFFFF); end
      n_checks++; if (pc_plus1 !== 16'h0000) begin n_fail++; $display("FAIL wrap_pc_plus1: got %h want %h", pc_plus1, 16'h0000); end
      branch_taken = 1'b0; imem_ready = 1'b1; imem_rdata = 16'hF0F0;
      @(negedge clk);
      n_checks++; if (instr !== 16'hF0F0) begin n_fail++; $display("FAIL wrap_instr: got %h want %h", instr, 16'hF0F0); end
      imem_ready = 1'b0;
      @(negedge clk);
      n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL wrap_next_pc: got %h want %h", pc, 16'h0000); end
      n_checks++; if (pc_plus1 !== 16'h0001) begin n_fail++; $display("FAIL wrap_next_plus1: got %h want %h", pc_plus1, 16'h0001); end
      $display("test_wrap: pc=%h pc_plus1=%h", pc, pc_plus1);
   endtask

   task automatic test_async_reset;
      branch_taken = 1'b1; branch_target = 16'h1234;
      @(negedge clk);
      branch_taken = 1'b0;
      n_checks++; if (pc !== 16'h1234) begin n_fail++; $display("FAIL ar_setup_pc: got %h want %h", pc, 16'h1234); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL ar_pc: got %h want %h", pc, 16'h0000); end
      n_checks++; if (imem_addr !== 16'h0000) begin n_fail++; $display("FAIL ar_addr: got %h want %h", imem_addr, 16'h0000); end
      n_checks++; if (instr !== 16'h0000) begin n_fail++; $display("FAIL ar_instr: got %h want %h", instr, 16'h0000); end
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL ar_req: got %b want 0", imem_req); end
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %b want 0", instr_valid); end
      imem_ready = 1'b1; imem_rdata = 16'hDEAD;
      @(negedge clk);
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL ar_held_req: got %b want 0", imem_req); end
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL ar_rel_req: got %b want 1", imem_req); end
      n_checks++; if (instr !== 16'h0000) begin n_fail++; $display("FAIL ar_rel_instr: got %h want %h", instr, 16'h0000); end
      @(negedge clk);
      n_checks++; if (instr !== 16'hDEAD) begin n_fail++; $display("FAIL ar_capture: got %h want %h", instr, 16'hDEAD); end
      $display("test_async_reset: pc=%h instr=%h", pc, instr);
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
      imem_ready = 1'b0; imem_rdata = 16'h0000;
      test_reset();
      test_reset_release();
      test_sequential();
      test_wait_states();
      test_stall_branch();
      test_branch_collision();
      test_wrap();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
